// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit for the lab processor: sequences fetch/decode/execute/
// memory/writeback, drives the ALU select lines and keeps a {C,Z,S} branch flag register.
module alu_ctrl_fsm #(
  parameter int OPW = 6,
  parameter int FNW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        carry,
  input  logic        zero,
  input  logic        sign,
  output logic        imem_rd,
  output logic        ir_load,
  output logic [4:0]  alu_op,
  output logic        comp_sel,
  output logic        alu_src,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_to_reg,
  output logic        reg_wr,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_RALU = OPW'(0);
  localparam logic [OPW-1:0] OP_IALU = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BR   = OPW'(4);
  localparam logic [OPW-1:0] OP_BZ   = OPW'(5);
  localparam logic [OPW-1:0] OP_BNZ  = OPW'(6);
  localparam logic [OPW-1:0] OP_BLTZ = OPW'(7);
  localparam logic [OPW-1:0] OP_BCY  = OPW'(8);
  localparam logic [OPW-1:0] OP_HALT = OPW'(63);
  localparam logic [FNW-1:0] FN_COMP = FNW'(1);

  state_t         state, next;
  logic [OPW-1:0] ir_op;
  logic [FNW-1:0] ir_fn;
  logic [2:0]     flags;

  logic [OPW-1:0] dec_op;
  logic           unused_instr;

  // Only the opcode and the resolved function field are kept in the IR.
  assign dec_op       = instr[31 -: OPW];
  assign unused_instr = ^{instr[25:21], instr[15:5]};

  function automatic logic [FNW-1:0] func_of(input logic [31:0] w);
    if (w[31 -: OPW] == OP_IALU) return w[16 +: FNW];
    return w[0 +: FNW];
  endfunction

  function automatic logic func_ok(input logic [FNW-1:0] f);
    return f <= FNW'(6);
  endfunction

  function automatic logic [4:0] func_op(input logic [FNW-1:0] f);
    case (f)
      FNW'(0): return 5'b00001;
      FNW'(1): return 5'b00101;
      FNW'(2): return 5'b00010;
      FNW'(3): return 5'b00011;
      FNW'(4): return 5'b01010;
      FNW'(5): return 5'b01000;
      FNW'(6): return 5'b01001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic op_legal(input logic [31:0] w);
    case (w[31 -: OPW])
      OP_RALU, OP_IALU:                          return func_ok(func_of(w));
      OP_LW, OP_SW, OP_BR, OP_BZ, OP_BNZ,
      OP_BLTZ, OP_BCY, OP_HALT:                  return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Branches test the registered flags {C,Z,S}, never the live ALU status.
  function automatic logic br_taken(input logic [OPW-1:0] op, input logic [2:0] f);
    case (op)
      OP_BR:   return 1'b1;
      OP_BZ:   return f[1];
      OP_BNZ:  return !f[1];
      OP_BLTZ: return f[0];
      OP_BCY:  return f[2];
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir_op   <= '0;
      ir_fn   <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        ir_op <= dec_op;
        ir_fn <= func_of(instr);
        if (!op_legal(instr)) illegal <= 1'b1;
      end
      if (state == S_EXEC && (ir_op == OP_RALU || ir_op == OP_IALU))
        flags <= {carry, zero, sign};
    end
  end

  always_comb begin
    next       = state;
    imem_rd    = 1'b0;
    ir_load    = 1'b0;
    alu_op     = 5'b00000;
    comp_sel   = 1'b0;
    alu_src    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 2'b00;
    halted     = 1'b0;
    case (state)
      S_IDLE: if (start) next = S_FETCH;
      S_FETCH: begin
        imem_rd = 1'b1;
        next    = S_DECODE;
      end
      S_DECODE: begin
        ir_load = 1'b1;
        if (dec_op == OP_HALT || !op_legal(instr)) next = S_HALT;
        else                                       next = S_EXEC;
      end
      S_EXEC: begin
        case (ir_op)
          OP_RALU, OP_IALU: begin
            alu_op   = func_op(ir_fn);
            comp_sel = (ir_fn == FN_COMP);
            alu_src  = (ir_op == OP_IALU);
            next     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op  = 5'b00001;
            alu_src = 1'b1;
            next    = S_MEM;
          end
          default: begin
            pc_en  = 1'b1;
            pc_sel = br_taken(ir_op, flags) ? 2'b01 : 2'b00;
            next   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (ir_op == OP_LW) begin
          mem_rd = 1'b1;
          next   = S_WB;
        end else begin
          mem_wr = 1'b1;
          pc_en  = 1'b1;
          next   = S_FETCH;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        pc_en      = 1'b1;
        mem_to_reg = (ir_op == OP_LW);
        next       = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: the driver queues the expected retirement of each
// instruction, the monitor checks it when pc_en pulses.
module tb_alu_ctrl_fsm;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        carry = 1'b0, zero = 1'b0, sign = 1'b0;
  logic        imem_rd, ir_load, comp_sel, alu_src, mem_rd, mem_wr, mem_to_reg;
  logic        reg_wr, pc_en, halted, illegal;
  logic [4:0]  alu_op;
  logic [1:0]  pc_sel;
  logic [17:0] outs;

  alu_ctrl_fsm #(.OPW(6), .FNW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .carry(carry), .zero(zero), .sign(sign),
    .imem_rd(imem_rd), .ir_load(ir_load), .alu_op(alu_op), .comp_sel(comp_sel),
    .alu_src(alu_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
    .reg_wr(reg_wr), .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted), .illegal(illegal)
  );

  assign outs = {imem_rd, ir_load, alu_op, comp_sel, alu_src, mem_rd, mem_wr,
                 mem_to_reg, reg_wr, pc_en, pc_sel, halted, illegal};

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] op;
    logic       cs, src;
    logic [1:0] psel;
    logic       rw, m2r, mrd, mwr;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: captures EXEC-cycle selects and memory strobes, compares on each pc_en.
  int         cyc = 0, fcyc = 0;
  logic       pend = 1'b0, rd_seen = 1'b0;
  logic [4:0] c_op = '0;
  logic       c_cs = 1'b0, c_src = 1'b0;
  exp_t       m;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        c_op = alu_op; c_cs = comp_sel; c_src = alu_src; pend = 1'b0;
      end
      if (ir_load) pend = 1'b1;
      if (imem_rd) begin fcyc = cyc; rd_seen = 1'b0; end
      if (mem_rd) rd_seen = 1'b1;
      if (pc_en) begin
        if (q.size() == 0) chk("unexpected_pc_en", 32'd1, 32'd0);
        else begin
          m = q.pop_front();
          chk({m.nm, ".alu_op"},     32'(c_op),       32'(m.op));
          chk({m.nm, ".comp_sel"},   32'(c_cs),       32'(m.cs));
          chk({m.nm, ".alu_src"},    32'(c_src),      32'(m.src));
          chk({m.nm, ".pc_sel"},     32'(pc_sel),     32'(m.psel));
          chk({m.nm, ".reg_wr"},     32'(reg_wr),     32'(m.rw));
          chk({m.nm, ".mem_to_reg"}, 32'(mem_to_reg), 32'(m.m2r));
          chk({m.nm, ".mem_rd"},     32'(rd_seen),    32'(m.mrd));
          chk({m.nm, ".mem_wr"},     32'(mem_wr),     32'(m.mwr));
          chk({m.nm, ".latency"},    32'(cyc - fcyc + 1), 32'(m.lat));
        end
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!imem_rd && n < 50) begin @(negedge clk); n++; end
    if (!imem_rd) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input string nm, input logic [31:0] w, input logic c, z, s,
                       input logic [4:0] op, input logic cs, src, input logic [1:0] psel,
                       input logic rw, m2r, mrd, mwr, input int lat);
    exp_t e;
    e.nm = nm; e.op = op; e.cs = cs; e.src = src; e.psel = psel;
    e.rw = rw; e.m2r = m2r; e.mrd = mrd; e.mwr = mwr; e.lat = lat;
    q.push_back(e);
    wait_fetch();
    start = 1'b0;
    instr = w;
    @(negedge clk);
    carry = c; zero = z; sign = s;
  endtask

  task automatic alu(input string nm, input logic [31:0] w, input logic c, z, s,
                     input logic [4:0] op, input logic cs, src);
    issue(nm, w, c, z, s, op, cs, src, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic br(input string nm, input logic [31:0] w, input logic c, z, s,
                    input logic [1:0] psel);
    issue(nm, w, c, z, s, 5'b00000, 1'b0, 1'b0, psel, 1'b0, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [17:0] acc;
    repeat (3) @(negedge clk);
    chk("reset_hold_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    acc = '0;
    repeat (5) begin @(negedge clk); acc |= outs; end
    chk("idle_no_start", 32'(acc), 32'd0);

    // Reset asserted during EXEC of an ADD.
    @(negedge clk); start = 1'b1;
    wait_fetch(); start = 1'b0; instr = 32'h0000_0000;
    @(negedge clk); zero = 1'b1;
    @(negedge clk);
    chk("exec_add_alu_op", 32'(alu_op), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_in_exec_outs", 32'(outs), 32'd0);
    acc = '0;
    repeat (3) begin @(negedge clk); acc |= outs; end
    chk("rst_in_exec_quiet", 32'(acc), 32'd0);
    rst_n = 1'b1;

    @(negedge clk); start = 1'b1;
    alu("add",    32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0);
    br ("bz_t1",  32'h1400_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    alu("icomp0", 32'h0401_0000, 1'b0, 1'b0, 1'b0, 5'b00101, 1'b1, 1'b1);
    br ("bz_nt",  32'h1400_0000, 1'b0, 1'b1, 1'b0, 2'b00);
    alu("icomp1", 32'h0401_0000, 1'b0, 1'b1, 1'b0, 5'b00101, 1'b1, 1'b1);
    br ("bz_t2",  32'h1400_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    issue("lw", 32'h0800_0000, 1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1, 2'b00,
          1'b1, 1'b1, 1'b1, 1'b0, 5);
    br ("bz_after_lw", 32'h1400_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    issue("sw", 32'h0C00_0000, 1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1, 2'b00,
          1'b0, 1'b0, 1'b0, 1'b1, 4);
    br ("bz_after_sw", 32'h1400_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    br ("bltz_nt",     32'h1C00_0000, 1'b0, 1'b0, 1'b1, 2'b00);
    alu("xor",    32'h0000_0003, 1'b0, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0);
    br ("bltz_t", 32'h1C00_0000, 1'b1, 1'b0, 1'b0, 2'b01);
    br ("bcy_nt", 32'h2000_0000, 1'b1, 1'b0, 1'b0, 2'b00);
    br ("bnz_t",  32'h1800_0000, 1'b0, 1'b1, 1'b0, 2'b01);
    alu("sll",    32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0);
    br ("bcy_t",  32'h2000_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    br ("br",     32'h1000_0000, 1'b0, 1'b0, 1'b0, 2'b01);
    alu("and",    32'h0000_0002, 1'b0, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b0);
    alu("isrl",   32'h0405_0000, 1'b0, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1);
    alu("sra",    32'h0000_0006, 1'b0, 1'b1, 1'b0, 5'b01001, 1'b0, 1'b0);
    br ("bnz_nt", 32'h1800_0000, 1'b0, 1'b0, 1'b0, 2'b00);

    // Illegal opcode 0x2A halts with the sticky illegal flag.
    wait_fetch(); instr = 32'hA800_0000;
    repeat (3) @(negedge clk);
    chk("illegal_halted", 32'(halted), 32'd1);
    chk("illegal_flag", 32'(illegal), 32'd1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("illegal_start_ignored", 32'(outs), 32'h3);
    do_reset();

    // HALT opcode.
    @(negedge clk); start = 1'b1;
    wait_fetch(); start = 1'b0; instr = 32'hFC00_0000;
    repeat (3) @(negedge clk);
    chk("halt_outs", 32'(outs), 32'h2);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_start_ignored", 32'(halted), 32'd1);
    do_reset();
    repeat (3) @(negedge clk);
    chk("after_reset_idle", 32'(outs), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
